hex_scan_driver: RTL and testbench

//   Time-multiplexed driver for a bank of DIGITS common-anode seven-segment digits.
//   - Captures a packed hex word and per-digit decimal points.
//   - Scans one digit at a time at a programmable refresh rate.
//   - Decodes each nibble 0-F to active-low segments.
//   - Sits between datapath/debug registers and the board display pins.

---
 rtl/hex_disp_pkg.sv | 14 +
 rtl/hex_seg_rom.sv | 9 +
 rtl/hex_scan_driver.sv | 85 ++++++++
 tb/tb_hex_scan_driver.sv | 109 ++++++++++
 4 files changed

// File: rtl/hex_disp_pkg.sv
// hex_disp_pkg: shared constants, seven-segment decode table and index width helper for hex_scan_driver
package hex_disp_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction
endpackage

// File: rtl/hex_seg_rom.sv
// hex_seg_rom: combinational nibble -> active-low segments (in nibble[3:0], out seg[6:0] = g..a)
module hex_seg_rom
  import hex_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = hex_to_seg(nibble);
endmodule

// File: rtl/hex_scan_driver.sv
// hex_scan_driver: multiplexed DIGITS-digit common-anode hex display driver; ports clk, reset, value, dp_in, load, blank -> seg, dp, an (active-low); optional LEADING_ZERO_BLANK_EN suppresses leading zeros
module hex_scan_driver
  import hex_disp_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int IDX_W       = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  blank,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an
);
  localparam int PW = $clog2(REFRESH_DIV);
  logic [PW-1:0] presc_q, presc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [4*DIGITS-1:0] pend_val_q, pend_val_d, act_val_q, act_val_d;
  logic [DIGITS-1:0] pend_dp_q, pend_dp_d, act_dp_q, act_dp_d, an_q, an_d;
  logic [6:0] seg_q, seg_d, rom_seg;
  logic dp_q, dp_d, tc, wrap, dp_bit, sup;
  logic [3:0] nib;
`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] sup_v;
  logic run;
`endif
  hex_seg_rom u_rom (.nibble(nib), .seg(rom_seg));
  always_comb begin
    tc         = presc_q == PW'(REFRESH_DIV - 1);
    wrap       = tc && (idx_q == IDX_W'(DIGITS - 1));
    presc_d    = tc ? '0 : presc_q + PW'(1);
    idx_d      = wrap ? '0 : tc ? idx_q + IDX_W'(1) : idx_q;
    pend_val_d = load ? value : pend_val_q;
    pend_dp_d  = load ? dp_in : pend_dp_q;
    // pending only reaches the display at frame end so a frame is never torn
    act_val_d  = wrap ? pend_val_q : act_val_q;
    act_dp_d   = wrap ? pend_dp_q : act_dp_q;
    nib        = 4'(act_val_q >> {idx_q, 2'b00});
    dp_bit     = 1'(act_dp_q >> idx_q);
`ifdef LEADING_ZERO_BLANK_EN
    run   = 1'b1;
    sup_v = '0;
    for (int k = DIGITS - 1; k > 0; k--) begin
      run      = run && (act_val_q[4*k +: 4] == 4'h0) && !act_dp_q[k];
      sup_v[k] = run;
    end
    sup = 1'(sup_v >> idx_q);
`else
    sup = 1'b0;
`endif
    seg_d = (blank || sup) ? SEG_BLANK : rom_seg;
    dp_d  = blank || !dp_bit;
    an_d  = blank ? '1 : ~(DIGITS'(1) << idx_q);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q    <= '0;
      idx_q      <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      act_val_q  <= '0;
      act_dp_q   <= '0;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b1;
      an_q       <= '1;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      act_val_q  <= act_val_d;
      act_dp_q   <= act_dp_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
    end
  end
  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;
endmodule

// File: tb/tb_hex_scan_driver.sv
// tb_hex_scan_driver: directed and random stimulus checked cycle by cycle against a frame-level model
module tb_hex_scan_driver;
  localparam int D = 4;
  localparam int R = 4;
  logic clk = 1'b0, reset = 1'b1, load = 1'b0, blank = 1'b0;
  logic [15:0] value = '0;
  logic [3:0] dp_in = '0, an;
  logic [6:0] seg;
  logic dp;
  int errors = 0, checks = 0, cnt = 0;
  logic [15:0] m_pend = '0, m_act = '0;
  logic [3:0] m_pend_dp = '0, m_act_dp = '0;
  logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  always #5 clk = ~clk;
  hex_scan_driver #(.DIGITS(D), .REFRESH_DIV(R), .IDX_W(3)) dut (
    .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .load(load),
    .blank(blank), .seg(seg), .dp(dp), .an(an)
  );
  function automatic bit suppressed(input logic [15:0] v, input logic [3:0] d, input int i);
`ifdef LEADING_ZERO_BLANK_EN
    if (i == 0) return 1'b0;
    for (int k = i; k < D; k++) if (v[4*k +: 4] != 4'h0 || d[k]) return 1'b0;
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction
  task automatic tick();
    logic [6:0] es;
    logic ed;
    logic [3:0] ea;
    int idx;
    idx = (cnt / R) % D;
    if (reset || blank) begin
      es = 7'h7F; ed = 1'b1; ea = 4'hF;
    end else begin
      es = suppressed(m_act, m_act_dp, idx) ? 7'h7F : dec[m_act[4*idx +: 4]];
      ed = ~m_act_dp[idx];
      ea = ~(4'b0001 << idx);
    end
    if (reset) begin
      cnt = 0; m_pend = '0; m_pend_dp = '0; m_act = '0; m_act_dp = '0;
    end else begin
      if (cnt == R*D - 1) begin
        m_act = m_pend; m_act_dp = m_pend_dp;
      end
      if (load) begin
        m_pend = value; m_pend_dp = dp_in;
      end
      cnt = (cnt + 1) % (R*D);
    end
    @(posedge clk);
    #1;
    checks++;
    assert (seg === es) else begin errors++; $error("FAIL seg: observed %h expected %h", seg, es); end
    checks++;
    assert (dp === ed) else begin errors++; $error("FAIL dp: observed %b expected %b", dp, ed); end
    checks++;
    assert (an === ea) else begin errors++; $error("FAIL an: observed %b expected %b", an, ea); end
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic load_word(input logic [15:0] v, input logic [3:0] d);
    value = v; dp_in = d; load = 1'b1;
    tick();
    load = 1'b0;
  endtask
  initial begin
    run(3);
    reset = 1'b0;
    run(2);
    load_word(16'h12AF, 4'b0000);
    run(40);
    while (cnt != 2) tick();
    load_word(16'h1111, 4'b0000);
    load_word(16'h2222, 4'b0000);
    run(36);
    while (cnt % R != 1) tick();
    blank = 1'b1;
    run(3);
    blank = 1'b0;
    run(10);
    load_word(16'h0050, 4'b0000);
    run(34);
    load_word(16'h0050, 4'b0100);
    run(34);
    while (cnt != R*D - 1) tick();
    load_word(16'hABCD, 4'b1010);
    run(34);
    load_word(16'h9876, 4'b0011);
    while (cnt != 2*R + 1) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run(40);
    for (int i = 0; i < 400; i++) begin
      load  = ($urandom % 6) == 0;
      value = 16'($urandom);
      dp_in = 4'($urandom);
      blank = ($urandom % 10) == 0;
      reset = ($urandom % 150) == 0;
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
